// File: rtl/data_memory_responder.sv
// data_memory_responder: byte-serial SRAM responder for 1/2/4/8-byte loads and stores
// under a four-phase memory_start/memory_done handshake.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_start,
    input  logic                  sel_mem_operation,
    input  logic [1:0]            sel_mem_size,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [63:0]           write_data,
    output logic [63:0]           read_data,
    output logic                  memory_done,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);
    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;
    state_t state, state_nx;
    logic                  op;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] base;
    logic [63:0]           wbuf;
    logic [2:0]            k;
    logic [2:0]            nm1;
    logic [2:0]            cap_idx;
    logic                  last, cap;
    // k wraps to 0 after the eighth byte, so k-1 still names the last byte in TAIL
    assign nm1     = {&size, size[1], |size};
    assign last    = k == nm1;
    assign cap_idx = k - 3'd1;
    assign cap     = (state == XFER && k != 3'd0 && !op) || state == TAIL;
    assign ram_en      = state == XFER;
    assign ram_we      = ram_en & op;
    assign ram_addr    = ram_en ? base + ADDR_WIDTH'(k) : '0;
    assign ram_wdata   = ram_en ? wbuf[{k, 3'b000} +: 8] : '0;
    assign memory_done = state == DONE;
    assign busy        = state == XFER || state == TAIL;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = memory_start ? XFER : IDLE;
            XFER:    state_nx = last ? (op ? DONE : TAIL) : XFER;
            TAIL:    state_nx = DONE;
            default: state_nx = memory_start ? DONE : IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op        <= 1'b0;
            size      <= 2'd0;
            base      <= '0;
            wbuf      <= '0;
            k         <= 3'd0;
            read_data <= '0;
        end else begin
            if (state == IDLE && memory_start) begin
                op   <= sel_mem_operation;
                size <= sel_mem_size;
                base <= address;
                wbuf <= write_data;
                k    <= 3'd0;
                if (!sel_mem_operation) read_data <= '0;
            end
            if (state == XFER) k <= k + 3'd1;
            if (cap) read_data[{cap_idx, 3'b000} +: 8] <= ram_rdata;
        end
    end
endmodule
